prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: RAM_DEPTH, 16, number of program RAM bytes; address width = 4.
REQ-002 Parameter: GAP_MAX, 255, maximum idle cycles allowed between accepted bytes during a load.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld_start  input  1  one-cycle request to begin a load.
REQ-006 byte_in  input  8  incoming stream byte.
REQ-007 byte_valid  input  1  byte_in valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 ram_addr  output  4  program RAM write address.
REQ-010 ram_data  output  8  program RAM write data (opcode nibble high, operand nibble low).
REQ-011 ram_we  output  1  program RAM write strobe, one cycle per byte.
REQ-012 cpu_hold  output  1  holds the CPU and instruction decoder idle (drives decoder rst) while loading.
REQ-013 done  output  1  one-cycle pulse on successful load.
REQ-014 err  output  1  sticky load error flag.

Function
REQ-015 A byte transfers only in a cycle where byte_valid and byte_ready are both 1.
REQ-016 States: IDLE, LEN, DATA, CSUM, FIN, ERR.
REQ-017 IDLE: byte_ready=0, cpu_hold=0; ld_start -> LEN, clear err, count, address, checksum and gap counter.
REQ-018 LEN: byte_ready=1; an accepted byte N with 1 <= N <= RAM_DEPTH -> DATA with remaining = N; N = 0 or N > RAM_DEPTH -> ERR.
REQ-019 DATA: byte_ready=1; each accepted byte is registered to ram_data with ram_addr = current address and ram_we=1 in the following cycle (latency 1); address increments; checksum += byte mod 256; the last byte -> CSUM.
REQ-020 CSUM: byte_ready=1; an accepted byte equal to the checksum -> FIN; any other value -> ERR.
REQ-021 FIN: done=1 for exactly one cycle, cpu_hold=0 from the next cycle on; -> IDLE.
REQ-022 ERR: err=1, cpu_hold=1, byte_ready=0; stays until ld_start, which behaves as in IDLE.
REQ-023 cpu_hold=1 in LEN, DATA, CSUM and FIN (it deasserts one cycle after done).
REQ-024 Gap counter counts consecutive cycles without a transfer in LEN, DATA and CSUM, and resets on each transfer; reaching GAP_MAX -> ERR.
REQ-025 ld_start in LEN, DATA, CSUM or FIN is ignored.
REQ-026 The address never wraps: at most RAM_DEPTH writes per load, the last at address RAM_DEPTH-1.
REQ-027 byte_valid while byte_ready=0 has no effect; the byte is not consumed.
REQ-028 ram_we is 0 in every cycle not following an accepted DATA byte.

Reset
REQ-029 rst has priority over all inputs, including mid-load, and yields state IDLE.
REQ-030 Reset values: byte_ready=0, ram_addr=0, ram_data=0x00, ram_we=0, cpu_hold=0, done=0, err=0; internal counters and checksum 0.
REQ-031 A load interrupted by rst is abandoned; RAM contents are left as written.

Structure
REQ-032 Shared package thistle_pkg holds the loader state enum, RAM_DEPTH, ADDR_W=4 and DATA_W=8.
REQ-033 Single flat module with no sub-modules; the checksum, address and gap counters are inline registers.

Verification
REQ-034 ld_start, then LEN=3, data B0,1E,2F, CSUM=FD -> three writes addr0=B0, addr1=1E, addr2=2F, each 1 cycle after its accept; done pulse; err=0; cpu_hold falls the cycle after done.
REQ-035 LEN=3, data 01,02,03, CSUM=07 -> ERR; err=1, cpu_hold=1, done never pulses; next ld_start clears err.
REQ-036 LEN=0 and LEN=17 -> ERR immediately; no ram_we.
REQ-037 LEN=16, data 00..0F, CSUM=78 -> writes at addresses 0..15, no wrap; done pulse.
REQ-038 byte_valid toggled every other cycle during DATA -> only handshaken bytes are written; byte_valid held 0 for GAP_MAX cycles after LEN -> ERR.
REQ-039 rst asserted after the second DATA byte -> all outputs take reset values the next cycle; a following full load succeeds.

Source files
------------

// File: rtl/thistle_pkg.sv
// Shared definitions for the program loader: loader state encoding,
// program RAM geometry and default timing limits.
package thistle_pkg;

    localparam int RAM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int GAP_MAX   = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream and
// writes it into the program RAM while holding the CPU idle. A stream is
// LEN, then LEN data bytes, then an 8-bit additive checksum of the data.
module prog_loader
    import thistle_pkg::ld_state_t;
    import thistle_pkg::ST_IDLE;
    import thistle_pkg::ST_LEN;
    import thistle_pkg::ST_DATA;
    import thistle_pkg::ST_CSUM;
    import thistle_pkg::ST_FIN;
    import thistle_pkg::ST_ERR;
    import thistle_pkg::ADDR_W;
    import thistle_pkg::DATA_W;
#(
    parameter int RAM_DEPTH = thistle_pkg::RAM_DEPTH,
    parameter int GAP_MAX   = thistle_pkg::GAP_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(RAM_DEPTH + 1);
    localparam int GAP_W = $clog2(GAP_MAX + 1);

    ld_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] csum;
    logic [GAP_W-1:0]  gap;

    logic xfer;
    logic len_ok;
    logic csum_match;
    logic gap_expired;
    logic last_byte;

    // Handshake and decision terms used by the sequencer below.
    always_comb begin
        xfer        = 1'b0;
        len_ok      = 1'b0;
        csum_match  = 1'b0;
        gap_expired = 1'b0;
        last_byte   = 1'b0;
        xfer        = byte_valid && byte_ready;
        len_ok      = (byte_in != '0) && (int'(byte_in) <= RAM_DEPTH);
        csum_match  = (byte_in == csum);
        gap_expired = (gap == GAP_W'(GAP_MAX - 1));
        last_byte   = (remaining == CNT_W'(1));
    end

    // Load sequencer: byte_ready is high exactly in LEN/DATA/CSUM, so it
    // doubles as the "actively receiving" flag for the idle-gap watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            csum       <= '0;
            gap        <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;

            if (byte_ready && !xfer && gap_expired) begin
                state      <= ST_ERR;
                byte_ready <= 1'b0;
                err        <= 1'b1;
                cpu_hold   <= 1'b1;
            end else begin
                if (byte_ready) begin
                    gap <= xfer ? '0 : gap + GAP_W'(1);
                end

                case (state)
                    ST_IDLE, ST_ERR: begin
                        if (ld_start) begin
                            state      <= ST_LEN;
                            byte_ready <= 1'b1;
                            cpu_hold   <= 1'b1;
                            err        <= 1'b0;
                            addr       <= '0;
                            remaining  <= '0;
                            csum       <= '0;
                            gap        <= '0;
                        end
                    end

                    ST_LEN: begin
                        if (xfer) begin
                            if (len_ok) begin
                                state     <= ST_DATA;
                                remaining <= CNT_W'(byte_in);
                            end else begin
                                state      <= ST_ERR;
                                byte_ready <= 1'b0;
                                err        <= 1'b1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (xfer) begin
                            ram_we    <= 1'b1;
                            ram_data  <= byte_in;
                            ram_addr  <= addr;
                            csum      <= csum + byte_in;
                            remaining <= remaining - CNT_W'(1);
                            if (last_byte) begin
                                state <= ST_CSUM;
                            end else begin
                                addr <= addr + ADDR_W'(1);
                            end
                        end
                    end

                    ST_CSUM: begin
                        if (xfer) begin
                            byte_ready <= 1'b0;
                            if (csum_match) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end

                    ST_FIN: begin
                        state    <= ST_IDLE;
                        cpu_hold <= 1'b0;
                    end

                    default: begin
                        state      <= ST_IDLE;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a stream-level model predicts the RAM
// writes and the load outcome, a scoreboard checks every write strobe.
module tb_prog_loader;

    localparam int RAM_DEPTH = 16;
    localparam int GAP_MAX   = 255;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] stream[$];
    wr_t        exp_wr[$];
    int         acc_q[$];
    int         n_data;
    logic       exp_ok;
    logic       done_now, err_now, hold_now, done_next, hold_next;

    prog_loader #(.RAM_DEPTH(RAM_DEPTH), .GAP_MAX(GAP_MAX)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the next predicted write and
    // appear exactly one cycle after the handshake that carried its byte.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            tests++;
            if (exp_wr.size() == 0 || acc_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%02h, expected no write", ram_addr, ram_data);
            end else begin
                wr_t w;
                int  a;
                w = exp_wr.pop_front();
                a = acc_q.pop_front();
                if (ram_addr !== w.a || ram_data !== w.d || cyc != a) begin
                    fails++;
                    $display("[TB] FAIL write: got addr=%0d data=%02h cyc=%0d, expected addr=%0d data=%02h cyc=%0d",
                             ram_addr, ram_data, cyc, w.a, w.d, a);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Build a stream: LEN, then LEN random data bytes and a checksum
    // (correct or deliberately off) when LEN is a legal length.
    task automatic make_stream(input int len, input bit good);
        int sum;
        logic [7:0] b;
        sum = 0;
        stream.delete();
        stream.push_back(8'(len));
        if (len >= 1 && len <= RAM_DEPTH) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                stream.push_back(b);
                sum += int'(b);
            end
            stream.push_back(good ? 8'(sum) : 8'(sum + int'($urandom_range(1, 255))));
        end
    endtask

    // Reference model: predicted writes and outcome from the stream alone.
    task automatic model_predict();
        int len;
        int sum;
        exp_wr.delete();
        acc_q.delete();
        len = int'(stream[0]);
        n_data = 0;
        exp_ok = 1'b0;
        if (len >= 1 && len <= RAM_DEPTH) begin
            sum = 0;
            for (int i = 1; i <= len; i++) begin
                exp_wr.push_back('{a: 4'(i - 1), d: stream[i]});
                sum = (sum + int'(stream[i])) % 256;
            end
            n_data = len;
            exp_ok = (int'(stream[len + 1]) == sum);
        end
    endtask

    // Drive one load; mode 0 = valid always, 1 = every other cycle,
    // 2 = random valid with stray ld_start pulses that must be ignored.
    task automatic run_load(input int mode);
        int   idx;
        bit   timeout;
        logic v;
        model_predict();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        idx = 0;
        timeout = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (byte_ready !== 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (c % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            if (idx >= stream.size()) v = 1'b0;
            byte_valid = v;
            byte_in = 8'($urandom);
            if (v) byte_in = stream[idx];
            ld_start = (mode == 2) && ($urandom_range(0, 7) == 0);
            if (v) begin
                if (idx >= 1 && idx <= n_data) acc_q.push_back(cyc + 1);
                idx++;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        ld_start = 1'b0;
        tests++;
        if (timeout) begin
            fails++;
            $display("[TB] FAIL load_timeout: byte_ready still %b after 600 cycles, expected 0", byte_ready);
        end
        done_now = done;
        err_now  = err;
        hold_now = cpu_hold;
        @(negedge clk);
        done_next = done;
        hold_next = cpu_hold;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_start = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'h05;
        repeat (2) @(negedge clk);
        tests++;
        if ({byte_ready, ram_addr, ram_data, ram_we, cpu_hold, done, err} !== 17'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {byte_ready, ram_addr, ram_data, ram_we, cpu_hold, done, err});
        end
        ld_start = 1'b0;
        byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got ready=%b hold=%b, expected 0/0", byte_ready, cpu_hold);
        end
    endtask

    task automatic test_basic();
        stream = '{8'h03, 8'hB0, 8'h1E, 8'h2F, 8'hFD};
        run_load(0);
        tests++;
        if (exp_ok !== 1'b1 || done_now !== 1'b1 || err_now !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_done: got done=%b err=%b, expected 1/0", done_now, err_now);
        end
        tests++;
        if (hold_now !== 1'b1 || hold_next !== 1'b0 || done_next !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_hold: got hold=%b,%b done_next=%b, expected 1,0 and 0", hold_now, hold_next, done_next);
        end
        tests++;
        if (exp_wr.size() != 0) begin
            fails++;
            $display("[TB] FAIL basic_writes: got %0d writes missing, expected 0", exp_wr.size());
        end
    endtask

    task automatic test_bad_csum();
        stream = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h07};
        run_load(0);
        tests++;
        if (done_now !== 1'b0 || err_now !== 1'b1 || hold_next !== 1'b1 || done_next !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bad_csum: got done=%b err=%b hold=%b, expected 0/1/1", done_now, err_now, hold_next);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_sticky: got err=%b hold=%b done=%b, expected 1/1/0", err, cpu_hold, done);
        end
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        tests++;
        if (err !== 1'b0 || byte_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_clear: got err=%b ready=%b, expected 0/1", err, byte_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bad_len();
        for (int k = 0; k < 2; k++) begin
            stream.delete();
            stream.push_back((k == 0) ? 8'd0 : 8'd17);
            run_load(0);
            tests++;
            if (err_now !== 1'b1 || done_now !== 1'b0 || hold_now !== 1'b1) begin
                fails++;
                $display("[TB] FAIL bad_len_%0d: got err=%b done=%b hold=%b, expected 1/0/1", stream[0], err_now, done_now, hold_now);
            end
        end
    endtask

    task automatic test_full();
        stream.delete();
        stream.push_back(8'd16);
        for (int i = 0; i < 16; i++) stream.push_back(8'(i));
        stream.push_back(8'h78);
        run_load(0);
        tests++;
        if (done_now !== 1'b1 || err_now !== 1'b0 || exp_wr.size() != 0) begin
            fails++;
            $display("[TB] FAIL full_load: got done=%b err=%b pending=%0d, expected 1/0/0", done_now, err_now, exp_wr.size());
        end
    endtask

    task automatic test_alternate();
        make_stream(5, 1'b1);
        run_load(1);
        tests++;
        if (done_now !== 1'b1 || err_now !== 1'b0 || exp_wr.size() != 0) begin
            fails++;
            $display("[TB] FAIL alternate: got done=%b err=%b pending=%0d, expected 1/0/0", done_now, err_now, exp_wr.size());
        end
    endtask

    task automatic test_gap();
        exp_wr.delete();
        acc_q.delete();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        byte_valid = 1'b0;
        repeat (GAP_MAX - 1) @(negedge clk);
        tests++;
        if (err !== 1'b0 || byte_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL gap_before_limit: got err=%b ready=%b, expected 0/1", err, byte_ready);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            fails++;
            $display("[TB] FAIL gap_at_limit: got err=%b ready=%b hold=%b, expected 1/0/1", err, byte_ready, cpu_hold);
        end
        byte_valid = 1'b1;
        byte_in = 8'h05;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        tests++;
        if (err !== 1'b1 || byte_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL valid_while_not_ready: got err=%b ready=%b, expected 1/0", err, byte_ready);
        end
    endtask

    task automatic test_reset_midload();
        make_stream(4, 1'b1);
        exp_wr.delete();
        acc_q.delete();
        exp_wr.push_back('{a: 4'd0, d: stream[1]});
        exp_wr.push_back('{a: 4'd1, d: stream[2]});
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_in = stream[i];
            if (i > 0) acc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({byte_ready, ram_addr, ram_data, ram_we, cpu_hold, done, err} !== 17'd0) begin
            fails++;
            $display("[TB] FAIL midload_reset: got %h, expected 0",
                     {byte_ready, ram_addr, ram_data, ram_we, cpu_hold, done, err});
        end
        tests++;
        if (exp_wr.size() != 0) begin
            fails++;
            $display("[TB] FAIL midload_writes: got %0d writes missing, expected 0", exp_wr.size());
        end
        rst = 1'b0;
        make_stream(6, 1'b1);
        run_load(0);
        tests++;
        if (done_now !== 1'b1 || err_now !== 1'b0 || exp_wr.size() != 0) begin
            fails++;
            $display("[TB] FAIL reload_after_reset: got done=%b err=%b pending=%0d, expected 1/0/0", done_now, err_now, exp_wr.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            make_stream($urandom_range(0, 18), ($urandom_range(0, 3) != 0));
            run_load(2);
            tests++;
            if (done_now !== exp_ok || err_now !== ~exp_ok || hold_next !== ~exp_ok || exp_wr.size() != 0) begin
                fails++;
                $display("[TB] FAIL random_%0d len=%0d: got done=%b err=%b hold=%b pending=%0d, expected done=%b",
                         n, stream[0], done_now, err_now, hold_next, exp_wr.size(), exp_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_len();
        test_full();
        test_alternate();
        test_gap();
        test_reset_midload();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
